// File: rtl/modport_en_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// modport_en_arbiter_pkg
// Shared types and helpers for the modport_en_arbiter block:
//   arb_state_t : arbiter FSM state encoding (IDLE, GRANT, RELEASE)
//   MAX_N_REQ   : largest supported requester count
//   rr_width(n) : width of a requester index for n requesters
// -----------------------------------------------------------------------------
package modport_en_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int MAX_N_REQ = 16;

  function automatic int rr_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/modport_en_arbiter_if.sv
// -----------------------------------------------------------------------------
// modport_en_arbiter_if
// Enable-driven shared resource interface. The arbiter owns the enable through
// the master modport; the shared resource observes it through the slave modport.
//   en : resource enable, high while some requester holds the grant
// -----------------------------------------------------------------------------
interface modport_en_arbiter_if;

  logic en;

  modport master (output en);
  modport slave  (input  en);

endinterface

// File: rtl/modport_en_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotate-priority picker. Searches the request vector
// starting at i_last+1 and wrapping around; i_last itself has lowest priority.
// Ports:
//   i_req    : request vector
//   i_last   : index of the most recently served requester
//   o_onehot : one-hot selection (all zero when nothing requested)
//   o_idx    : index of the selection (0 when nothing requested)
//   o_any    : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import modport_en_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int W     = rr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [W-1:0]     i_last,
  output logic [N_REQ-1:0] o_onehot,
  output logic [W-1:0]     o_idx,
  output logic             o_any
);

  int w_pos;

  // Walk the search order backwards so the highest-priority hit is the last
  // assignment and therefore the one that sticks.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_pos = (int'(i_last) + k) % N_REQ;
      if (i_req[w_pos]) begin
        o_onehot        = '0;
        o_onehot[w_pos] = 1'b1;
        o_idx           = W'(w_pos);
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modport_en_arbiter.sv
// -----------------------------------------------------------------------------
// modport_en_arbiter
// Round-robin arbiter sharing one enable-driven resource between N_REQ
// requesters, with a one-cycle release gap between owners.
// Optional watchdog: define MODPORT_EN_ARBITER_TIMEOUT_EN to revoke any grant
// held for MAX_HOLD cycles.
// Ports:
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset
//   i_req     : per-requester request level, held for the whole use
//   o_gnt     : one-hot registered grant
//   o_gnt_id  : owner index, meaningful only while o_en=1
//   o_en      : resource enable, equals |o_gnt
//   o_busy    : high in GRANT and RELEASE
//   o_timeout : one-cycle pulse coincident with a forced RELEASE
//   o_res     : shared resource interface, enable driven through master modport
// -----------------------------------------------------------------------------
module modport_en_arbiter
  import modport_en_arbiter_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 8,
  localparam int W        = rr_width(N_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req,
  output logic [N_REQ-1:0]     o_gnt,
  output logic [W-1:0]         o_gnt_id,
  output logic                 o_en,
  output logic                 o_busy,
  output logic                 o_timeout,
  modport_en_arbiter_if.master o_res
);

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [W-1:0]     r_gnt_id, w_gnt_id_nxt;
  logic [W-1:0]     r_last, w_last_nxt;
  logic [N_REQ-1:0] w_pick_onehot;
  logic [W-1:0]     w_pick_idx;
  logic             w_pick_any;
  logic             w_owner_req;
  logic             w_hold_hit;
  logic             w_unused_cfg;

  // Out-of-range configuration flag; not connected to any output.
  assign w_unused_cfg = (N_REQ > MAX_N_REQ) | (MAX_HOLD > 255);

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_owner_req = i_req[r_gnt_id];

`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
  logic [7:0] r_hold, w_hold_nxt;
  logic       r_timeout, w_timeout_nxt;

  // Counter holds (grant cycles - 1), so the MAX_HOLD-th grant cycle is the last.
  assign w_hold_hit = (r_hold + 8'd1) == 8'(MAX_HOLD);
  assign o_timeout  = r_timeout;
`else
  assign w_hold_hit = 1'b0;
  assign o_timeout  = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_last    <= W'(N_REQ - 1);
`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
      r_hold    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_last    <= w_last_nxt;
`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any) w_state_nxt = GRANT;
      GRANT:   if (!w_owner_req || w_hold_hit) w_state_nxt = RELEASE;
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_last_nxt   = r_last;
`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_gnt_nxt    = w_pick_onehot;
          w_gnt_id_nxt = w_pick_idx;
`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
          w_hold_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        if (!w_owner_req || w_hold_hit) begin
          // Owner (voluntary or revoked) counts as served.
          w_gnt_nxt  = '0;
          w_last_nxt = r_gnt_id;
`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
          // A simultaneous voluntary drop is not a forced revoke.
          w_timeout_nxt = w_hold_hit && w_owner_req;
`endif
        end else begin
`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
          w_hold_nxt = r_hold + 8'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_id  = r_gnt_id;
  assign o_en      = |r_gnt;
  assign o_busy    = (r_state != IDLE);
  assign o_res.en  = |r_gnt;

endmodule

// File: tb/tb_modport_en_arbiter.sv
// -----------------------------------------------------------------------------
// tb_modport_en_arbiter
// Directed scenarios followed by random request traffic. Every cycle the DUT
// outputs are compared with a behavioural model that tracks the owner as an
// integer, the last served requester and a pending release gap.
// Honours MODPORT_EN_ARBITER_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_modport_en_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 8;
  localparam int W    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_id;
  logic         en, busy, timeout;

  always #5 clk = ~clk;

  modport_en_arbiter_if res_if ();

  modport_en_arbiter #(.N_REQ(N), .MAX_HOLD(MAXH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .o_gnt     (gnt),
    .o_gnt_id  (gnt_id),
    .o_en      (en),
    .o_busy    (busy),
    .o_timeout (timeout),
    .o_res     (res_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_owner = -1;   // -1: nobody owns the resource
  int m_last  = N - 1;
  int m_hold  = 0;    // grant cycles completed by the current owner
  bit m_rel   = 1'b0; // in the one-cycle gap after an owner leaves
  bit m_to    = 1'b0;

  function automatic void model_step(input logic [N-1:0] r, input logic rs);
    m_to = 1'b0;
    if (rs) begin
      m_owner = -1; m_last = N - 1; m_hold = 0; m_rel = 1'b0;
    end else if (m_owner >= 0) begin
      m_hold++;
      if (!r[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_rel = 1'b1;
      end
`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
      else if (m_hold == MAXH) begin
        m_to = 1'b1; m_last = m_owner; m_owner = -1; m_rel = 1'b1;
      end
`endif
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (r[c]) begin
          m_owner = c; m_hold = 0;
          break;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    chk("gnt",     32'(gnt),       32'(eg));
    chk("en",      32'(en),        32'(m_owner >= 0));
    chk("res_en",  32'(res_if.en), 32'(m_owner >= 0));
    chk("busy",    32'(busy),      32'((m_owner >= 0) || m_rel));
    chk("timeout", 32'(timeout),   32'(m_to));
    if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, check.
  task automatic step(input logic [N-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    logic [N-1:0] rr;
    int           waited;
    int           owner;

    req = '0;
    rst = 1'b1;
    @(negedge clk);

    // Reset held 3 cycles with all requests high
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1);
      chk("rst_gnt",  32'(gnt),  32'h0);
      chk("rst_en",   32'(en),   32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_to",   32'(timeout), 32'h0);
    end
    step(4'b1111, 1'b0);
    chk("rst_first_gnt", 32'(gnt), 32'h1);

    // Single requester 2, dropped in its fifth grant cycle
    step(4'b0000, 1'b1);
    for (int t = 1; t <= 5; t++) begin
      step(4'b0100, 1'b0);
      chk("single_gnt", 32'(gnt),    32'h4);
      chk("single_id",  32'(gnt_id), 32'd2);
    end
    step(4'b0000, 1'b0);
    chk("single_en_off", 32'(en),   32'h0);
    chk("single_rel",    32'(busy), 32'h1);
    step(4'b0000, 1'b0);
    chk("single_idle",   32'(busy), 32'h0);

    // Round-robin fairness with all four requesting
    step(4'b0000, 1'b1);
    for (int r = 0; r < 5; r++) begin
      waited = 0;
      while (!en && waited < 10) begin
        step(4'b1111, 1'b0);
        waited++;
      end
      chk("rr_grant_seen", 32'(en),     32'h1);
      chk("rr_order",      32'(gnt_id), 32'(r % N));
      owner = (m_owner >= 0) ? m_owner : 0;
      step(4'b1111, 1'b0);
      step(4'b1111 & ~(N'(1) << owner), 1'b0);
    end

    // Wrap-around from last=3
    step(4'b0000, 1'b1);
    step(4'b1001, 1'b0);
    chk("wrap_first", 32'(gnt), 32'h1);
    step(4'b1001, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);
    chk("wrap_next", 32'(gnt), 32'h8);

    // Owner 1 drops while requester 2 raises in the same cycle
    step(4'b0000, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    chk("simul_rel_en",   32'(en),   32'h0);
    chk("simul_rel_busy", 32'(busy), 32'h1);
    step(4'b0100, 1'b0);
    chk("simul_idle",     32'(busy), 32'h0);
    step(4'b0100, 1'b0);
    chk("simul_gnt",      32'(gnt),  32'h4);

    // Reset asserted mid-grant
    step(4'b0100, 1'b1);
    chk("midrst_gnt",  32'(gnt),  32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);

    // Watchdog: requester 0 never lets go, requester 1 waits
    step(4'b0011, 1'b0);
    chk("wd_first", 32'(gnt), 32'h1);
`ifdef MODPORT_EN_ARBITER_TIMEOUT_EN
    for (int i = 0; i < MAXH - 1; i++) begin
      step(4'b0011, 1'b0);
      chk("wd_hold_en", 32'(en), 32'h1);
    end
    step(4'b0011, 1'b0);
    chk("wd_timeout", 32'(timeout), 32'h1);
    chk("wd_rel_en",  32'(en),      32'h0);
    step(4'b0011, 1'b0);
    chk("wd_to_pulse", 32'(timeout), 32'h0);
    step(4'b0011, 1'b0);
    chk("wd_next_gnt", 32'(gnt), 32'h2);
`else
    for (int i = 0; i < MAXH + 4; i++) begin
      step(4'b0011, 1'b0);
      chk("nowd_gnt", 32'(gnt),     32'h1);
      chk("nowd_to",  32'(timeout), 32'h0);
    end
`endif

    // Random traffic: each request bit toggles with probability 1/8
    step(4'b0000, 1'b1);
    rr = '0;
    for (int i = 0; i < 600; i++) begin
      rr = rr ^ (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
      step(rr, ($urandom_range(0, 59) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/modport_en_arbiter.md
# modport_en_arbiter

Round-robin arbiter that shares one enable-driven resource (an interface whose modport drives a single `en` output) between `N_REQ` requesters. It sits between the requesting modules and the shared interface instance: it grants ownership to one requester at a time, drives the resource enable while the grant is held, and inserts a one-cycle release gap between owners. An optional watchdog forcibly revokes grants held too long.

## Interface
Parameters:
- `N_REQ`, default 4, number of requesters (2..16).
- `MAX_HOLD`, default 8, maximum grant length in cycles when the watchdog is compiled in (1..255).

Ports:
- `i_clk`, input, 1, clock; all state updates on the rising edge.
- `i_rst`, input, 1, reset; one clock, synchronous, active-high.
- `i_req`, input, `N_REQ`, per-requester request level; held high for the whole use.
- `o_gnt`, output, `N_REQ`, one-hot grant, registered.
- `o_gnt_id`, output, `$clog2(N_REQ)`, index of the current owner; valid only while `o_en`=1.
- `o_en`, output, 1, enable to the shared resource's modport `en`; equals `|o_gnt`.
- `o_busy`, output, 1, high in GRANT and RELEASE.
- `o_timeout`, output, 1, one-cycle pulse on a forced revoke.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- Reset: state=IDLE, `o_gnt`=0, `o_gnt_id`=0, `o_en`=0, `o_busy`=0, `o_timeout`=0, round-robin pointer `last`=`N_REQ`-1, hold counter=0.
- IDLE: if `|i_req`, select the first asserted requester searching from `last`+1 upward with wrap-around. Load `o_gnt`/`o_gnt_id` and go to GRANT. Otherwise stay.
- GRANT: `o_en`=1. Stay while `i_req[o_gnt_id]`=1. When the owner drops its request, go to RELEASE.
- RELEASE: `o_gnt`=0 and `o_en`=0 for exactly one cycle. Set `last`=previous owner, then go to IDLE.
- Requests from non-owners during GRANT or RELEASE are ignored. They are arbitrated in IDLE.
- A requester that drops `i_req` before it is granted loses its turn; there is no request latching.
- If the owner re-requests immediately, it is granted only after all other pending requesters have been served.
- Reset asserted mid-grant: all outputs return to reset values on the next edge with no RELEASE cycle.

## Timing
- Request-to-grant latency: `i_req` high in cycle t while in IDLE gives `o_gnt` and `o_en` high in cycle t+1.
- Release latency: owner `i_req` low in cycle t gives `o_en` low in cycle t+1 (RELEASE) and IDLE in t+2. The earliest next grant is visible in t+3.
- Minimum gap between two owners is 2 cycles of `o_en`=0 (RELEASE plus IDLE).
- All outputs are registered; there is no combinational path from `i_req` to any output.

## Configuration
- Macro: `MODPORT_EN_ARBITER_TIMEOUT_EN`.
- With the macro defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches `MAX_HOLD`, the FSM goes to RELEASE regardless of `i_req`, and `o_timeout` pulses for one cycle coincident with RELEASE.
  - The revoked owner is treated as served: `last` is updated to it.
- Without the macro: no counter exists, `o_timeout` is tied to 0, and grants last indefinitely.

## Structure
- Shared package `modport_en_arbiter_pkg`:
  - `arb_state_t` enum (IDLE, GRANT, RELEASE).
  - `MAX_N_REQ`=16 constant.
  - Function `rr_width(n)` returning `$clog2(n)`.
- Sub-module `rr_pick`: purely combinational rotate-priority picker. Inputs are the request vector and `last`. Outputs are a one-hot vector, an index and `any`. It is instantiated once, and the FSM registers its outputs.

## Test plan
- Reset: hold `i_rst`=1 for 3 cycles with `i_req`=4'b1111. Required: all outputs 0 throughout, and the first grant after release goes to requester 0 (`o_gnt`=4'b0001).
- Single requester: `i_req`=4'b0100 at t=0 and dropped at t=5. Required: `o_gnt`=4'b0100 and `o_gnt_id`=2 for t=1..5, `o_en`=0 at t=6, `o_busy`=0 at t=7.
- Round-robin fairness: `i_req`=4'b1111, each owner dropping its request 2 cycles after grant and re-raising it after release. Required: grant order 0,1,2,3,0.
- Wrap-around: `last`=3 with `i_req`=4'b1001. Required: requester 0 is granted; next round requester 3 is granted.
- Simultaneous events: owner 1 drops its request in the same cycle requester 2 raises its request. Required: one RELEASE cycle, one IDLE cycle, then `o_gnt`=4'b0100.
- Watchdog (macro defined, `MAX_HOLD`=8): requester 0 holds `i_req` high permanently and requester 1 is also requesting. Required: `o_en` high for 8 cycles, `o_timeout` pulses for one cycle, then requester 1 is granted. With the macro undefined, requester 0 keeps the grant and `o_timeout` stays 0.
